// File: rtl/fifo_wr_arbiter.sv
// Write-side FIFO controller: round-robin arbitration of NREQ producers onto one memory write port.
// Optional macro ARB_BURST_EN keeps priority on a requester for up to BURST_LEN consecutive grants.
module fifo_wr_arbiter #(
    parameter int WIDTH     = 32,
    parameter int ADDR      = 5,
    parameter int NREQ      = 4,
    parameter int BURST_LEN = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    output logic [NREQ-1:0]           req_ready,
    input  logic [ADDR:0]             rptr,
    output logic                      write,
    output logic [ADDR-1:0]           waddr,
    output logic [WIDTH-1:0]          wdata,
    output logic                      wfull,
    output logic [ADDR:0]             wptr,
    output logic [ADDR:0]             level,
    output logic [$clog2(NREQ)-1:0]   gnt_id
);

    localparam int IW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || BURST_LEN < 1) begin : g_bad_param
        $error("fifo_wr_arbiter: NREQ must be 2..8 and BURST_LEN >= 1");
    end

    logic [IW-1:0] rr_last;
    logic [IW-1:0] winner;
    logic          found;
    logic          grant;
    int            start_idx;

`ifdef ARB_BURST_EN
    localparam int CW = $clog2(BURST_LEN + 1);
    logic [CW-1:0] burst_cnt;
    logic [CW-1:0] burst_cnt_next;
    logic          hold;
`endif

    assign wfull = (wptr[ADDR] != rptr[ADDR]) && (wptr[ADDR-1:0] == rptr[ADDR-1:0]);
    assign level = wptr - rptr;

    // Circular priority search beginning one past the last winner (or on it while a burst is held).
    always_comb begin
        logic [IW-1:0] idx_b;
        found  = 1'b0;
        winner = '0;
        idx_b  = '0;
`ifdef ARB_BURST_EN
        start_idx = (hold && req_valid[rr_last]) ? int'(rr_last) : (int'(rr_last) + 1) % NREQ;
`else
        start_idx = (int'(rr_last) + 1) % NREQ;
`endif
        for (int k = 0; k < NREQ; k++) begin
            idx_b = IW'((start_idx + k) % NREQ);
            if (!found && req_valid[idx_b]) begin
                found  = 1'b1;
                winner = idx_b;
            end
        end
    end

    assign grant = found & ~wfull & ~reset;

    always_comb begin
        req_ready = '0;
        wdata     = '0;
        if (grant) begin
            req_ready[winner] = 1'b1;
            wdata             = req_data[int'(winner)*WIDTH +: WIDTH];
        end
    end

    assign write = grant;
    assign waddr = wptr[ADDR-1:0];

`ifdef ARB_BURST_EN
    always_comb begin
        burst_cnt_next = '0;
        if (hold && winner == rr_last)
            burst_cnt_next = burst_cnt + 1'b1;
    end
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr    <= '0;
            gnt_id  <= '0;
            rr_last <= IW'(NREQ - 1);
`ifdef ARB_BURST_EN
            burst_cnt <= '0;
            hold      <= 1'b0;
`endif
        end else if (grant) begin
            wptr    <= wptr + 1'b1;
            gnt_id  <= winner;
            rr_last <= winner;
`ifdef ARB_BURST_EN
            burst_cnt <= burst_cnt_next;
            hold      <= (burst_cnt_next < CW'(BURST_LEN - 1));
`endif
        end else begin
`ifdef ARB_BURST_EN
            // The burst owner dropping valid ends its burst even without a transfer.
            if (hold && !req_valid[rr_last]) begin
                burst_cnt <= '0;
                hold      <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table plus hand-written multi-cycle sequences.
// Default build checks round-robin rotation; with ARB_BURST_EN it checks burst grants instead.
module tb_fifo_wr_arbiter;

    localparam int WIDTH = 32;
    localparam int ADDR  = 5;
    localparam int NREQ  = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic [ADDR:0]         rptr;
    logic                  write;
    logic [ADDR-1:0]       waddr;
    logic [WIDTH-1:0]      wdata;
    logic                  wfull;
    logic [ADDR:0]         wptr;
    logic [ADDR:0]         level;
    logic [1:0]            gnt_id;

    int n_cmp = 0;
    int n_bad = 0;

    fifo_wr_arbiter #(.WIDTH(WIDTH), .ADDR(ADDR), .NREQ(NREQ), .BURST_LEN(4)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .rptr(rptr), .write(write), .waddr(waddr),
        .wdata(wdata), .wfull(wfull), .wptr(wptr), .level(level), .gnt_id(gnt_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] valid;
        logic [5:0] rptr;
        logic [3:0] ready;
        logic       write;
        logic [4:0] waddr;
        logic       wfull;
        logic [5:0] level;
        logic [5:0] wptr_n;
        logic [1:0] gnt_n;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] data_of(input logic [3:0] ready);
        data_of = '0;
        for (int i = 0; i < NREQ; i++)
            if (ready[i]) data_of = 32'hC0DE_0000 + 32'(i);
    endfunction

    task automatic apply_vec(input vec_t v, input int n);
        @(negedge clk);
        reset     = v.rst;
        req_valid = v.valid;
        rptr      = v.rptr;
        #1;
        check($sformatf("v%0d.ready", n), 64'(req_ready), 64'(v.ready));
        check($sformatf("v%0d.write", n), 64'(write), 64'(v.write));
        check($sformatf("v%0d.waddr", n), 64'(waddr), 64'(v.waddr));
        check($sformatf("v%0d.wdata", n), 64'(wdata), 64'(data_of(v.ready)));
        check($sformatf("v%0d.wfull", n), 64'(wfull), 64'(v.wfull));
        check($sformatf("v%0d.level", n), 64'(level), 64'(v.level));
        @(posedge clk);
        #1;
        check($sformatf("v%0d.wptr", n), 64'(wptr), 64'(v.wptr_n));
        check($sformatf("v%0d.gnt_id", n), 64'(gnt_id), 64'(v.gnt_n));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        req_valid = '0;
        rptr      = '0;
        @(posedge clk);
        #1;
        check("reset.wptr", 64'(wptr), 64'd0);
        check("reset.gnt_id", 64'(gnt_id), 64'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic expect_grant(input logic [3:0] valid, input int id, input string tag);
        @(negedge clk);
        req_valid = valid;
        #1;
        check({tag, ".ready"}, 64'(req_ready), 64'(4'b0001 << id));
        check({tag, ".write"}, 64'(write), 64'd1);
        @(posedge clk);
    endtask

    initial begin
        vec_t vecs[15];
        logic [5:0] exp_wptr;

        reset     = 1'b1;
        req_valid = '0;
        rptr      = '0;
        for (int i = 0; i < NREQ; i++)
            req_data[i*WIDTH +: WIDTH] = 32'hC0DE_0000 + 32'(i);

`ifndef ARB_BURST_EN
        // rst valid rptr | ready write waddr wfull level | wptr' gnt'
        vecs[0]  = '{1'b1, 4'b1111, 6'd0, 4'b0000, 1'b0, 5'd0, 1'b0, 6'd0, 6'd0, 2'd0};
        vecs[1]  = '{1'b0, 4'b1111, 6'd0, 4'b0001, 1'b1, 5'd0, 1'b0, 6'd0, 6'd1, 2'd0};
        vecs[2]  = '{1'b0, 4'b1111, 6'd0, 4'b0010, 1'b1, 5'd1, 1'b0, 6'd1, 6'd2, 2'd1};
        vecs[3]  = '{1'b0, 4'b1111, 6'd0, 4'b0100, 1'b1, 5'd2, 1'b0, 6'd2, 6'd3, 2'd2};
        vecs[4]  = '{1'b0, 4'b1111, 6'd0, 4'b1000, 1'b1, 5'd3, 1'b0, 6'd3, 6'd4, 2'd3};
        vecs[5]  = '{1'b0, 4'b1101, 6'd0, 4'b0001, 1'b1, 5'd4, 1'b0, 6'd4, 6'd5, 2'd0};
        vecs[6]  = '{1'b0, 4'b1101, 6'd0, 4'b0100, 1'b1, 5'd5, 1'b0, 6'd5, 6'd6, 2'd2};
        vecs[7]  = '{1'b0, 4'b1101, 6'd0, 4'b1000, 1'b1, 5'd6, 1'b0, 6'd6, 6'd7, 2'd3};
        vecs[8]  = '{1'b0, 4'b1101, 6'd0, 4'b0001, 1'b1, 5'd7, 1'b0, 6'd7, 6'd8, 2'd0};
        vecs[9]  = '{1'b0, 4'b0000, 6'd0, 4'b0000, 1'b0, 5'd8, 1'b0, 6'd8, 6'd8, 2'd0};
        vecs[10] = '{1'b0, 4'b0000, 6'd3, 4'b0000, 1'b0, 5'd8, 1'b0, 6'd5, 6'd8, 2'd0};
        vecs[11] = '{1'b1, 4'b1111, 6'd0, 4'b0000, 1'b0, 5'd8, 1'b0, 6'd8, 6'd0, 2'd0};
        vecs[12] = '{1'b0, 4'b1111, 6'd0, 4'b0001, 1'b1, 5'd0, 1'b0, 6'd0, 6'd1, 2'd0};
        vecs[13] = '{1'b0, 4'b1001, 6'd0, 4'b1000, 1'b1, 5'd1, 1'b0, 6'd1, 6'd2, 2'd3};
        vecs[14] = '{1'b0, 4'b1001, 6'd0, 4'b0001, 1'b1, 5'd2, 1'b0, 6'd2, 6'd3, 2'd0};
        for (int n = 0; n < 15; n++)
            apply_vec(vecs[n], n);
`else
        do_reset();
        begin
            int seq_a[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 2};
            for (int n = 0; n < 9; n++)
                expect_grant(4'b1111, seq_a[n], $sformatf("burst_a%0d", n));
        end
        do_reset();
        expect_grant(4'b1111, 0, "burst_b0");
        expect_grant(4'b1111, 0, "burst_b1");
        for (int n = 0; n < 4; n++)
            expect_grant(4'b1110, 1, $sformatf("burst_b%0d", n + 2));
`endif

        // Single requester fills the FIFO, then one slot frees.
        do_reset();
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            req_valid = 4'b0100;
            rptr      = '0;
            #1;
            check($sformatf("fill%0d.ready", k), 64'(req_ready), 64'b0100);
            check($sformatf("fill%0d.waddr", k), 64'(waddr), 64'(k));
            check($sformatf("fill%0d.wdata", k), 64'(wdata), 64'h0000_0000_C0DE_0002);
            @(posedge clk);
        end
        @(negedge clk);
        #1;
        check("full.wptr", 64'(wptr), 64'b100000);
        check("full.wfull", 64'(wfull), 64'd1);
        check("full.level", 64'(level), 64'd32);
        check("full.ready", 64'(req_ready), 64'd0);
        check("full.write", 64'(write), 64'd0);
        check("full.wdata", 64'(wdata), 64'd0);
        @(posedge clk);
        #1;
        check("stall.wptr", 64'(wptr), 64'd32);
        check("stall.gnt_id", 64'(gnt_id), 64'd2);
        @(negedge clk);
        rptr = 6'd1;
        #1;
        check("free.wfull", 64'(wfull), 64'd0);
        check("free.write", 64'(write), 64'd1);
        check("free.waddr", 64'(waddr), 64'd0);
        @(posedge clk);
        #1;
        check("refull.wptr", 64'(wptr), 64'd33);
        check("refull.wfull", 64'(wfull), 64'd1);

        // Advance to wptr=63 with rptr trailing, then wrap.
        exp_wptr = 6'd33;
        while (exp_wptr != 6'd63) begin
            @(negedge clk);
            rptr = exp_wptr - 6'd2;
            @(posedge clk);
            exp_wptr = exp_wptr + 6'd1;
        end
        @(negedge clk);
        rptr = 6'd60;
        #1;
        check("wrap.wptr_pre", 64'(wptr), 64'd63);
        check("wrap.waddr", 64'(waddr), 64'd31);
        check("wrap.level_pre", 64'(level), 64'd3);
        check("wrap.write", 64'(write), 64'd1);
        @(posedge clk);
        #1;
        check("wrap.wptr", 64'(wptr), 64'd0);
        check("wrap.level", 64'(level), 64'd4);
        check("wrap.wfull", 64'(wfull), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
